// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC, IR and MDR holding stage of the multicycle MIPS datapath.
// Applies the PC-update strobes from control_unit, decodes the IR fields
// and keeps retired-instruction / taken-branch debug counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWrite,
  input  logic                 BEQ,
  input  logic                 BNE,
  input  logic [1:0]           PCSrc,
  input  logic                 IRWrite,
  input  logic                 Zero,
  input  logic [31:0]          ALUResult,
  input  logic [31:0]          ALUOut,
  input  logic [31:0]          MemRdata,
  input  logic                 CntClr,
  output logic [31:0]          PC,
  output logic [31:0]          Instr,
  output logic [5:0]           Opcode,
  output logic [5:0]           Funct,
  output logic [4:0]           Rs,
  output logic [4:0]           Rt,
  output logic [4:0]           Rd,
  output logic [15:0]          Imm16,
  output logic [31:0]          MDR,
  output logic                 Misaligned,
  output logic [CNT_WIDTH-1:0] InstrCount,
  output logic [CNT_WIDTH-1:0] BranchCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]          r_pc;
  logic [31:0]          r_ir;
  logic [31:0]          r_mdr;
  logic                 r_mis;
  logic [CNT_WIDTH-1:0] r_icnt;
  logic [CNT_WIDTH-1:0] r_bcnt;

  logic                 w_taken;
  logic                 w_pc_en;
  logic                 w_pc_load;
  logic [31:0]          w_next_pc;

  // Branch resolution; BEQ and BNE together always resolve taken.
  assign w_taken = (BEQ & Zero) | (BNE & ~Zero);
  assign w_pc_en = PCWrite | w_taken;
  // PCSrc=11 is reserved: PC and Misaligned both hold even with pc_en.
  assign w_pc_load = w_pc_en & (PCSrc != 2'b11);

  // Next-PC mux; jump target uses current PC and IR, before this edge's updates.
  always_comb begin
    w_next_pc = r_pc;
    unique case (PCSrc)
      2'b00:   w_next_pc = ALUResult;
      2'b01:   w_next_pc = ALUOut;
      2'b10:   w_next_pc = {r_pc[31:28], r_ir[25:0], 2'b00};
      default: w_next_pc = r_pc;
    endcase
  end

  // PC register and sticky misalignment flag (cleared only by reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_PC;
      r_mis <= 1'b0;
    end else if (w_pc_load) begin
      r_pc <= w_next_pc;
      if (w_next_pc[1:0] != 2'b00) r_mis <= 1'b1;
    end
  end

  // IR loads on IRWrite; MDR captures memory read data every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir  <= 32'h0;
      r_mdr <= 32'h0;
    end else begin
      r_mdr <= MemRdata;
      if (IRWrite) r_ir <= MemRdata;
    end
  end

  // Debug counters; clear wins over a same-cycle increment, both wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_icnt <= '0;
      r_bcnt <= '0;
    end else if (CntClr) begin
      r_icnt <= '0;
      r_bcnt <= '0;
    end else begin
      if (IRWrite) r_icnt <= r_icnt + CNT_ONE;
      if (w_taken) r_bcnt <= r_bcnt + CNT_ONE;
    end
  end

  // Field decode always comes from the IR register, never from MemRdata.
  assign PC          = r_pc;
  assign Instr       = r_ir;
  assign Opcode      = r_ir[31:26];
  assign Rs          = r_ir[25:21];
  assign Rt          = r_ir[20:16];
  assign Rd          = r_ir[15:11];
  assign Funct       = r_ir[5:0];
  assign Imm16       = r_ir[15:0];
  assign MDR         = r_mdr;
  assign Misaligned  = r_mis;
  assign InstrCount  = r_icnt;
  assign BranchCount = r_bcnt;

endmodule
